// File: rtl/mux2_arbiter.sv
// Two-channel valid/ready merge into a single registered output slot.
// Define MUX2_ARBITER_RR_EN for round-robin contention; default is fixed B priority.
module mux2_arbiter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_b_valid,
  output logic             in_b_ready,
  input  logic [WIDTH-1:0] in_c,
  input  logic             in_c_valid,
  output logic             in_c_ready,
  output logic [WIDTH-1:0] A_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sel
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_sel;
  // last-grant pointer: 0 = B, 1 = C
  logic             r_last;

  logic             w_load_en;
  logic             w_grant_b;
  logic             w_grant_c;
  logic             w_take_b;
  logic             w_take_c;

  assign w_load_en = !r_valid || out_ready;

  // pick at most one channel; contention policy depends on build option
  always_comb begin
    w_grant_b = 1'b0;
    w_grant_c = 1'b0;
    if (in_b_valid && in_c_valid) begin
`ifdef MUX2_ARBITER_RR_EN
      w_grant_b = r_last;
      w_grant_c = !r_last;
`else
      w_grant_b = 1'b1;
`endif
    end else if (in_b_valid) begin
      w_grant_b = 1'b1;
    end else if (in_c_valid) begin
      w_grant_c = 1'b1;
    end
  end

`ifndef MUX2_ARBITER_RR_EN
  // pointer is tracked but does not steer the fixed-priority grant
  logic w_unused_last;
  assign w_unused_last = r_last;
`endif

  // readys are held low during reset so nothing is consumed then
  assign w_take_b   = !rst && w_load_en && w_grant_b;
  assign w_take_c   = !rst && w_load_en && w_grant_c;
  assign in_b_ready = w_take_b;
  assign in_c_ready = w_take_c;

  // output slot: load on accept, empty on drain, hold under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
    end else if (w_load_en) begin
      if (w_take_b) begin
        r_data  <= in_b;
        r_valid <= 1'b1;
        r_sel   <= 1'b0;
        r_last  <= 1'b0;
      end else if (w_take_c) begin
        r_data  <= in_c;
        r_valid <= 1'b1;
        r_sel   <= 1'b1;
        r_last  <= 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign A_out     = r_data;
  assign out_valid = r_valid;
  assign out_sel   = r_sel;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed vector bench for mux2_arbiter.
// Expectations follow MUX2_ARBITER_RR_EN when it is defined.
module tb_mux2_arbiter;

`ifdef MUX2_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic [1:0] b;
    logic       bv;
    logic [1:0] c;
    logic       cv;
    logic       ordy;
    logic       e_br;
    logic       e_cr;
    logic [1:0] e_a;
    logic       e_sel;
    logic       e_v;
    logic       chk_d;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [1:0] in_b;
  logic       in_b_valid;
  logic       in_b_ready;
  logic [1:0] in_c;
  logic       in_c_valid;
  logic       in_c_ready;
  logic [1:0] A_out;
  logic       out_valid;
  logic       out_ready;
  logic       out_sel;

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];

  mux2_arbiter #(.WIDTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_b       (in_b),
    .in_b_valid (in_b_valid),
    .in_b_ready (in_b_ready),
    .in_c       (in_c),
    .in_c_valid (in_c_valid),
    .in_c_ready (in_c_ready),
    .A_out      (A_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sel    (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx,
                     input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %b want %b", nm, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic r, input logic [1:0] b, input logic bv,
    input logic [1:0] c, input logic cv, input logic ordy,
    input logic ebr, input logic ecr, input logic [1:0] ea,
    input logic esel, input logic ev, input logic cd);
    vec_t v;
    v.rst = r;   v.b = b;     v.bv = bv;
    v.c = c;     v.cv = cv;   v.ordy = ordy;
    v.e_br = ebr; v.e_cr = ecr;
    v.e_a = ea;  v.e_sel = esel; v.e_v = ev;
    v.chk_d = cd;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst        = v.rst;
    in_b       = v.b;
    in_b_valid = v.bv;
    in_c       = v.c;
    in_c_valid = v.cv;
    out_ready  = v.ordy;
    #1;
    chk("b_ready", idx, {1'b0, in_b_ready}, {1'b0, v.e_br});
    chk("c_ready", idx, {1'b0, in_c_ready}, {1'b0, v.e_cr});
    @(posedge clk);
    #1;
    chk("out_valid", idx, {1'b0, out_valid}, {1'b0, v.e_v});
    if (v.chk_d) begin
      chk("A_out", idx, A_out, v.e_a);
      chk("out_sel", idx, {1'b0, out_sel}, {1'b0, v.e_sel});
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_b       = 2'b00;
    in_b_valid = 1'b0;
    in_c       = 2'b00;
    in_c_valid = 1'b0;
    out_ready  = 1'b0;

    // reset with both inputs valid
    vecs.push_back(mk(1, 2'b01, 1, 2'b11, 1, 1, 0, 0, 2'b00, 0, 0, 1));
    vecs.push_back(mk(1, 2'b01, 1, 2'b11, 1, 1, 0, 0, 2'b00, 0, 0, 1));
    // single C beat, first edge after reset, then drain
    vecs.push_back(mk(0, 2'b00, 0, 2'b10, 1, 1, 0, 1, 2'b10, 1, 1, 1));
    vecs.push_back(mk(0, 2'b00, 0, 2'b00, 0, 1, 0, 0, 2'b00, 0, 0, 0));
    // contention, full throughput
    vecs.push_back(mk(0, 2'b01, 1, 2'b11, 1, 1, 1, 0, 2'b01, 0, 1, 1));
    vecs.push_back(mk(0, 2'b01, 1, 2'b11, 1, 1, !RR, RR,
                      RR ? 2'b11 : 2'b01, RR, 1, 1));
    vecs.push_back(mk(0, 2'b01, 1, 2'b11, 1, 1, 1, 0, 2'b01, 0, 1, 1));
    vecs.push_back(mk(0, 2'b01, 1, 2'b11, 1, 1, !RR, RR,
                      RR ? 2'b11 : 2'b01, RR, 1, 1));
    // backpressure: three stalled cycles, held beat stable
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 2'b01, 1, 2'b11, 1, 0, 0, 0,
                        RR ? 2'b11 : 2'b01, RR, 1, 1));
    // release: drain and load C on the same edge
    vecs.push_back(mk(0, 2'b00, 0, 2'b11, 1, 1, 0, 1, 2'b11, 1, 1, 1));
    vecs.push_back(mk(0, 2'b01, 1, 2'b00, 0, 0, 0, 0, 2'b11, 1, 1, 1));
    // reset mid-stream discards held beat
    vecs.push_back(mk(1, 2'b01, 1, 2'b11, 1, 0, 0, 0, 2'b00, 0, 0, 1));
    // B first after release
    vecs.push_back(mk(0, 2'b01, 1, 2'b11, 1, 0, 1, 0, 2'b01, 0, 1, 1));
    vecs.push_back(mk(0, 2'b01, 1, 2'b11, 1, 1, !RR, RR,
                      RR ? 2'b11 : 2'b01, RR, 1, 1));
    vecs.push_back(mk(0, 2'b00, 0, 2'b00, 0, 1, 0, 0, 2'b00, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], i);

    // hand sequence: single B beat, bounded wait for acceptance
    begin
      int  n;
      bit  got;
      @(negedge clk);
      in_b       = 2'b10;
      in_b_valid = 1'b1;
      in_c_valid = 1'b0;
      out_ready  = 1'b1;
      got = 0;
      n   = 0;
      while (!got && n < 5) begin
        #1;
        if (in_b_ready) got = 1;
        else begin
          @(negedge clk);
          n++;
        end
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL b_accept: no ready within 5 cycles, want ready");
      end
      @(posedge clk);
      #1;
      chk("seq_A_out", 100, A_out, 2'b10);
      chk("seq_sel", 100, {1'b0, out_sel}, 2'b00);
      @(negedge clk);
      in_b_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("seq_drain", 101, {1'b0, out_valid}, 2'b00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
